mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Purpose : MEM-stage load/store unit with request/ready bus and timeout abort.
// Revision: 1.0
// ============================================================================
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        mem_write,
   input  logic        wb_load,
   input  logic [1:0]  mem_store_type,
   input  logic [2:0]  mem_load_type,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misaligned,
   output logic        bus_error
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;
   logic [3:0]  r_bus_wstrb;
   logic        r_is_load;
   logic [1:0]  r_lane;
   logic [2:0]  r_ltype;
   logic [31:0] r_load_data;
   logic        r_load_valid;
   logic        r_misaligned;
   logic        r_bus_error;

   logic        w_is_store;
   logic        w_start;
   logic        w_is_byte;
   logic        w_is_half;
   logic        w_aligned;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;
   logic        w_accept;
   logic        w_timeout;
   logic        w_stall;

   // Store wins over load when both controls are set.
   assign w_is_store = mem_write && (mem_store_type != 2'b11);
   assign w_start    = valid_in && (w_is_store || wb_load);

   always_comb begin
      w_is_byte = 1'b0;
      w_is_half = 1'b0;
      if (w_is_store) begin
         w_is_byte = (mem_store_type == 2'b00);
         w_is_half = (mem_store_type == 2'b01);
      end else begin
         w_is_byte = (mem_load_type == 3'b000) || (mem_load_type == 3'b011);
         w_is_half = (mem_load_type == 3'b001) || (mem_load_type == 3'b100);
      end
   end

   assign w_aligned = w_is_byte || (w_is_half && !addr[0]) || (addr[1:0] == 2'b00);

   always_comb begin
      w_wstrb = 4'b0000;
      w_wdata = 32'd0;
      if (w_is_store) begin
         if (w_is_byte) begin
            w_wstrb = 4'b0001 << addr[1:0];
            w_wdata = {4{store_data[7:0]}};
         end else if (w_is_half) begin
            w_wstrb = 4'b0011 << addr[1:0];
            w_wdata = {2{store_data[15:0]}};
         end else begin
            w_wstrb = 4'b1111;
            w_wdata = store_data;
         end
      end
   end

   always_comb begin
      w_byte = bus_rdata[7:0];
      case (r_lane)
         2'd1:    w_byte = bus_rdata[15:8];
         2'd2:    w_byte = bus_rdata[23:16];
         2'd3:    w_byte = bus_rdata[31:24];
         default: w_byte = bus_rdata[7:0];
      endcase
   end

   assign w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      w_ext = bus_rdata;
      case (r_ltype)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b011:  w_ext = {24'd0, w_byte};
         3'b100:  w_ext = {16'd0, w_half};
         default: w_ext = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_accept    = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start && w_aligned) begin
               w_accept    = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            w_stall = 1'b1;
            if (bus_ready) begin
               w_state_nxt = S_DONE;
            end else if (r_cnt == c_TIMEOUT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= 8'd0;
         r_bus_req    <= 1'b0;
         r_bus_we     <= 1'b0;
         r_bus_addr   <= 32'd0;
         r_bus_wdata  <= 32'd0;
         r_bus_wstrb  <= 4'b0000;
         r_is_load    <= 1'b0;
         r_lane       <= 2'd0;
         r_ltype      <= 3'd0;
         r_load_data  <= 32'd0;
         r_load_valid <= 1'b0;
         r_misaligned <= 1'b0;
         r_bus_error  <= 1'b0;
      end else begin
         r_load_valid <= 1'b0;
         r_misaligned <= 1'b0;
         r_bus_error  <= 1'b0;
         if (w_accept) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_is_store;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_wdata <= w_wdata;
            r_bus_wstrb <= w_wstrb;
            r_is_load   <= !w_is_store;
            r_lane      <= addr[1:0];
            r_ltype     <= mem_load_type;
            r_cnt       <= 8'd0;
         end else if (r_state == S_IDLE && w_start) begin
            r_misaligned <= 1'b1;
         end else if (r_state == S_BUSY) begin
            if (bus_ready) begin
               r_bus_req <= 1'b0;
               if (r_is_load) begin
                  r_load_data  <= w_ext;
                  r_load_valid <= 1'b1;
               end
            end else if (w_timeout) begin
               r_bus_req   <= 1'b0;
               r_load_data <= 32'd0;
               r_bus_error <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 8'd1;
            end
         end
      end
   end

   assign bus_req    = r_bus_req;
   assign bus_we     = r_bus_we;
   assign bus_addr   = r_bus_addr;
   assign bus_wdata  = r_bus_wdata;
   assign bus_wstrb  = r_bus_wstrb;
   // Gated so a start presented during reset cannot raise stall.
   assign stall      = w_stall && !rst;
   assign load_data  = r_load_data;
   assign load_valid = r_load_valid;
   assign misaligned = r_misaligned;
   assign bus_error  = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_unit
// Purpose : Directed scoreboard bench for mem_access_unit (TIMEOUT_CYCLES = 4).
// Revision: 1.0
// ============================================================================
module tb_mem_access_unit;

   localparam int c_TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic        mem_write;
   logic        wb_load;
   logic [1:0]  mem_store_type;
   logic [2:0]  mem_load_type;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        misaligned;
   logic        bus_error;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic [31:0] baddr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic        lv;
      logic [31:0] ld;
      logic        err;
   } exp_t;

   exp_t sb[$];

   mem_access_unit #(.TIMEOUT_CYCLES(c_TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_in       (valid_in),
      .mem_write      (mem_write),
      .wb_load        (wb_load),
      .mem_store_type (mem_store_type),
      .mem_load_type  (mem_load_type),
      .addr           (addr),
      .store_data     (store_data),
      .bus_req        (bus_req),
      .bus_we         (bus_we),
      .bus_addr       (bus_addr),
      .bus_wdata      (bus_wdata),
      .bus_wstrb      (bus_wstrb),
      .bus_ready      (bus_ready),
      .bus_rdata      (bus_rdata),
      .stall          (stall),
      .load_data      (load_data),
      .load_valid     (load_valid),
      .misaligned     (misaligned),
      .bus_error      (bus_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req"},   {31'd0, bus_req},    32'd0);
      chk({tag, "_stall"}, {31'd0, stall},      32'd0);
      chk({tag, "_we"},    {31'd0, bus_we},     32'd0);
      chk({tag, "_addr"},  bus_addr,            32'd0);
      chk({tag, "_wdata"}, bus_wdata,           32'd0);
      chk({tag, "_wstrb"}, {28'd0, bus_wstrb},  32'd0);
      chk({tag, "_ld"},    load_data,           32'd0);
      chk({tag, "_lv"},    {31'd0, load_valid}, 32'd0);
      chk({tag, "_mis"},   {31'd0, misaligned}, 32'd0);
      chk({tag, "_err"},   {31'd0, bus_error},  32'd0);
   endtask

   task automatic drive_idle();
      valid_in       = 1'b0;
      mem_write      = 1'b0;
      wb_load        = 1'b0;
      mem_store_type = 2'b11;
      mem_load_type  = 3'b000;
      addr           = 32'd0;
      store_data     = 32'd0;
   endtask

   // Called just after a rising edge; returns just after the edge that ends DONE.
   // rdy = BUSY cycle carrying bus_ready (0 = never, run into timeout).
   task automatic access(input string tag, input logic is_st, input logic [1:0] st,
                         input logic [2:0] lt, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int rdy, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata, input logic e_lv, input logic [31:0] e_ld,
                         input logic e_err);
      exp_t e;
      exp_t got;
      bit   fin;
      e.we    = is_st;
      e.baddr = {a[31:2], 2'b00};
      e.strb  = e_strb;
      e.wdata = e_wdata;
      e.lv    = e_lv;
      e.ld    = e_ld;
      e.err   = e_err;
      sb.push_back(e);
      valid_in       = 1'b1;
      mem_write      = is_st;
      wb_load        = !is_st;
      mem_store_type = st;
      mem_load_type  = lt;
      addr           = a;
      store_data     = sd;
      @(negedge clk);
      chk({tag, "_acc_stall"}, {31'd0, stall},   32'd1);
      chk({tag, "_acc_req"},   {31'd0, bus_req}, 32'd0);
      @(posedge clk); #1;
      drive_idle();
      fin = 1'b0;
      for (int k = 1; k <= c_TO && !fin; k++) begin
         bus_ready = (k == rdy);
         bus_rdata = (k == rdy) ? rd : 32'hDEAD_0000;
         @(negedge clk);
         chk({tag, "_busy_req"},   {31'd0, bus_req}, 32'd1);
         chk({tag, "_busy_stall"}, {31'd0, stall},   32'd1);
         if (k == 1) begin
            chk({tag, "_we"},    {31'd0, bus_we},   {31'd0, e.we});
            chk({tag, "_addr"},  bus_addr,          e.baddr);
            chk({tag, "_wstrb"}, {28'd0, bus_wstrb}, {28'd0, e.strb});
            if (e.we) chk({tag, "_wdata"}, bus_wdata, e.wdata);
         end
         @(posedge clk); #1;
         bus_ready = 1'b0;
         if (k == rdy) fin = 1'b1;
      end
      @(negedge clk);
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
      end else begin
         got = sb.pop_front();
         chk({tag, "_done_stall"}, {31'd0, stall},      32'd0);
         chk({tag, "_done_req"},   {31'd0, bus_req},    32'd0);
         chk({tag, "_done_hold"},  bus_addr,            got.baddr);
         chk({tag, "_lv"},         {31'd0, load_valid}, {31'd0, got.lv});
         chk({tag, "_ld"},         load_data,           got.ld);
         chk({tag, "_err"},        {31'd0, bus_error},  {31'd0, got.err});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst       = 1'b1;
      bus_ready = 1'b0;
      bus_rdata = 32'd0;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // SB, lane 3, ready on BUSY cycle 2
      access("sb", 1'b1, 2'b00, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 2,
             4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0, 1'b0);
      access("lb", 1'b0, 2'b11, 3'b000, 32'h0000_1001, 32'h0, 32'h0000_8000, 1,
             4'b0000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
      access("lbu", 1'b0, 2'b11, 3'b011, 32'h0000_1001, 32'h0, 32'h0000_8000, 1,
             4'b0000, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
      access("lh", 1'b0, 2'b11, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1,
             4'b0000, 32'h0, 1'b1, 32'hFFFF_BEEF, 1'b0);
      // store leaves load_data untouched
      access("sh", 1'b1, 2'b01, 3'b000, 32'h0000_0102, 32'h1234_5678, 32'h0, 3,
             4'b1100, 32'h5678_5678, 1'b0, 32'hFFFF_BEEF, 1'b0);
      access("lhu", 1'b0, 2'b11, 3'b100, 32'h0000_0300, 32'h0, 32'h7777_8001, 1,
             4'b0000, 32'h0, 1'b1, 32'h0000_8001, 1'b0);

      // misaligned LW: one-cycle pulse, no request, no stall
      valid_in      = 1'b1;
      wb_load       = 1'b1;
      mem_load_type = 3'b010;
      addr          = 32'h0000_1002;
      @(negedge clk);
      chk("mis_c0_stall", {31'd0, stall},      32'd0);
      chk("mis_c0_req",   {31'd0, bus_req},    32'd0);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk("mis_pulse",    {31'd0, misaligned}, 32'd1);
      chk("mis_c1_stall", {31'd0, stall},      32'd0);
      chk("mis_c1_req",   {31'd0, bus_req},    32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_end",      {31'd0, misaligned}, 32'd0);
      @(posedge clk); #1;

      access("timeout", 1'b0, 2'b11, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 0,
             4'b0000, 32'h0, 1'b0, 32'h0, 1'b1);
      // ready in the final BUSY cycle beats the timeout
      access("lw_last", 1'b0, 2'b11, 3'b111, 32'h0000_4000, 32'h0, 32'h1357_9BDF, c_TO,
             4'b0000, 32'h0, 1'b1, 32'h1357_9BDF, 1'b0);

      // reset on BUSY cycle 2
      valid_in      = 1'b1;
      wb_load       = 1'b1;
      mem_load_type = 3'b010;
      addr          = 32'h0000_5000;
      @(posedge clk); #1;
      drive_idle();
      @(posedge clk); #1;
      chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      access("sw_after_rst", 1'b1, 2'b10, 3'b000, 32'h0000_0010, 32'h1122_3344, 32'h0, 1,
             4'b1111, 32'h1122_3344, 1'b0, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
